// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot path.
//
// Contents:
//   WORD_W          instruction word width in bits
//   BYTE_W          stream byte width in bits
//   loader_state_e  program_loader FSM states
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    // Loader FSM: two header bytes, then per word four DATA bytes
    // followed by one WRITE cycle. DONE and ERROR are parking states
    // that only a start pulse or reset can leave.
    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// program_loader
//
// Boot-time loader in front of the single-cycle MIPS core's instruction
// memory. It takes a byte stream made of a 16-bit big-endian word-count
// header followed by count*4 bytes. It assembles big-endian 32-bit words and
// writes them to instruction memory from byte address 0 upward. The core is
// held in reset until the whole image has been written.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   in_valid      in_data carries a byte
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   start         one-cycle reload request, honoured in DONE or ERROR only
//   imem_we       instruction-memory write strobe, one cycle per word
//   imem_addr     word-aligned byte address of the write
//   imem_wdata    word being written
//   cpu_resetN    active-low core reset, high only in DONE
//   done          image loaded, core released
//   error         header count exceeded DEPTH_WORDS
//   words_loaded  words written since the load began
module program_loader
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    input  logic                start,
    output logic                imem_we,
    output logic [WORD_W-1:0]   imem_addr,
    output logic [WORD_W-1:0]   imem_wdata,
    output logic                cpu_resetN,
    output logic                done,
    output logic                error,
    output logic [CNT_W-1:0]    words_loaded
);

    localparam logic [CNT_W:0] DEPTH_L = DEPTH_WORDS[CNT_W:0];

    loader_state_e                state, next_state;
    logic [CNT_W-1:0]             count_q;
    logic [CNT_W-1:0]             word_idx;
    logic [1:0]                   byte_idx;
    logic [WORD_W-BYTE_W-1:0]     word_q;
    logic                         accept;
    logic [CNT_W-1:0]             hdr_count;
    logic                         last_word;

    // State register. Reset takes priority over everything, including start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_HI;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The full header count is formed from the stored
    // high byte and the low byte that is arriving now. This lets HDR_LO
    // branch straight to DONE or ERROR without an extra cycle.
    always_comb begin
        next_state = state;
        accept     = in_valid & in_ready;
        hdr_count  = {count_q[CNT_W-1:BYTE_W], in_data};
        last_word  = (word_idx == count_q - CNT_W'(1));
        case (state)
            HDR_HI: begin
                if (accept) next_state = HDR_LO;
            end
            HDR_LO: begin
                if (accept) begin
                    if (hdr_count == '0)
                        next_state = DONE;
                    else if ({1'b0, hdr_count} > DEPTH_L)
                        next_state = ERROR;
                    else
                        next_state = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                next_state = last_word ? DONE : DATA;
            end
            DONE, ERROR: begin
                if (start) next_state = HDR_HI;
            end
            default: next_state = HDR_HI;
        endcase
    end

    // Status outputs are registered copies of next-state decodes. They
    // therefore line up with the state register, and no input reaches an
    // output combinationally. During reset all of them read 0. As a result,
    // in_ready comes up one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            cpu_resetN <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            in_ready   <= (next_state == HDR_HI) || (next_state == HDR_LO) ||
                          (next_state == DATA);
            imem_we    <= (next_state == WRITE);
            cpu_resetN <= (next_state == DONE);
            done       <= (next_state == DONE);
            error      <= (next_state == ERROR);
        end
    end

    // Datapath: header capture, byte shifter and word counters.
    // Bytes are shifted in from the right, so the first byte ends up in
    // [31:24]. On the fourth byte, address and data are latched directly
    // into the output registers. They are then stable for the WRITE cycle
    // and hold their values afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_q       <= '0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                HDR_HI: begin
                    if (accept) count_q[CNT_W-1:BYTE_W] <= in_data;
                end
                HDR_LO: begin
                    if (accept) count_q[BYTE_W-1:0] <= in_data;
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        word_q   <= {word_q[WORD_W-2*BYTE_W-1:0], in_data};
                        if (byte_idx == 2'd3) begin
                            imem_addr  <= {{(WORD_W-CNT_W-2){1'b0}}, word_idx, 2'b00};
                            imem_wdata <= {word_q, in_data};
                        end
                    end
                end
                WRITE: begin
                    word_idx     <= word_idx + CNT_W'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                end
                DONE, ERROR: begin
                    if (start) begin
                        word_idx     <= '0;
                        byte_idx     <= '0;
                        words_loaded <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//
// Directed testbench for program_loader. Each scenario task drives a byte
// stream and compares the DUT outputs against hand-computed values. A
// negedge monitor logs every instruction-memory write so that scenarios can
// check the complete write sequence.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        start = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_resetN;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr [0:299];
    logic [31:0] wr_data [0:299];
    int          wr_count = 0;
    int          base;

    program_loader #(.DEPTH_WORDS(256), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_resetN   (cpu_resetN),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Record each memory write mid-cycle, while the strobe is stable.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_count < 300) begin
                wr_addr[wr_count] = imem_addr;
                wr_data[wr_count] = imem_wdata;
            end
            wr_count = wr_count + 1;
        end
    end

    // Synchronous reset pulse that spans exactly one rising edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one byte from a negedge and hold it until the DUT is ready.
    // The wait is bounded. The task returns on the negedge after the byte
    // is accepted. If gap is set, it adds one idle cycle with in_valid low.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (gap) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [15:0] cnt, input bit gap);
        send_byte(cnt[15:8], gap);
        send_byte(cnt[7:0], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    // Every output is checked while reset is held, and in_ready is checked
    // again once reset has been released.
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if ({in_ready, imem_we, cpu_resetN, done, error} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b required=00000",
                     {in_ready, imem_we, cpu_resetN, done, error});
        end
        checks++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus addr=%h wdata=%h required=0/0", imem_addr, imem_wdata);
        end
        checks++;
        if (words_loaded !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_words got=%0d required=0", words_loaded);
        end
        checks++;
        reset = 1'b0;
        @(negedge clk);
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got=%b required=1", in_ready);
        end
        checks++;
    endtask

    // Two-word image with no gaps. The checks cover write timing and the
    // release of the core on the cycle after the last write.
    task automatic test_basic();
        do_reset();
        base = wr_count;
        send_hdr(16'd2, 1'b0);
        send_word(32'h20080005, 1'b0);
        send_word(32'h8C090004, 1'b0);
        if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h8C090004) begin
            errors++;
            $display("[TB] FAIL basic_write2 we=%b addr=%h wdata=%h required=1/4/8c090004",
                     imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if (done !== 1'b0 || cpu_resetN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_early_done done=%b cpu_resetN=%b required=0/0", done, cpu_resetN);
        end
        checks++;
        @(negedge clk);
        if (done !== 1'b1 || cpu_resetN !== 1'b1 || imem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_release done=%b cpu_resetN=%b we=%b required=1/1/0",
                     done, cpu_resetN, imem_we);
        end
        checks++;
        if (words_loaded !== 16'd2 || imem_addr !== 32'h4) begin
            errors++;
            $display("[TB] FAIL basic_hold words=%0d addr=%h required=2/4", words_loaded, imem_addr);
        end
        checks++;
        if (wr_count - base !== 2 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h20080005 ||
            wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h8C090004) begin
            errors++;
            $display("[TB] FAIL basic_log n=%0d w0=%h@%h w1=%h@%h required=2 20080005@0 8c090004@4",
                     wr_count - base, wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]);
        end
        checks++;
    endtask

    // A zero-length image releases the core at once and never writes memory.
    task automatic test_zero_count();
        do_reset();
        base = wr_count;
        send_hdr(16'd0, 1'b0);
        if (done !== 1'b1 || cpu_resetN !== 1'b1 || words_loaded !== 16'd0) begin
            errors++;
            $display("[TB] FAIL zero_done done=%b cpu_resetN=%b words=%0d required=1/1/0",
                     done, cpu_resetN, words_loaded);
        end
        checks++;
        repeat (3) @(negedge clk);
        if (wr_count - base !== 0) begin
            errors++;
            $display("[TB] FAIL zero_nowrite writes=%0d required=0", wr_count - base);
        end
        checks++;
    endtask

    // A count of 257 is rejected. The test checks that ERROR refuses bytes
    // and that a start pulse clears it.
    task automatic test_oversize();
        do_reset();
        send_hdr(16'h0101, 1'b0);
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_resetN !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oversize_err error=%b ready=%b cpu_resetN=%b done=%b required=1/0/0/0",
                     error, in_ready, cpu_resetN, done);
        end
        checks++;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        if (error !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oversize_sticky error=%b ready=%b required=1/0", error, in_ready);
        end
        checks++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (error !== 1'b0 || in_ready !== 1'b1 || words_loaded !== 16'd0) begin
            errors++;
            $display("[TB] FAIL oversize_clear error=%b ready=%b words=%0d required=0/1/0",
                     error, in_ready, words_loaded);
        end
        checks++;
    endtask

    // The same image as the basic test, with one idle cycle after every byte.
    task automatic test_gaps();
        do_reset();
        base = wr_count;
        send_hdr(16'd2, 1'b1);
        send_word(32'h20080005, 1'b1);
        send_word(32'h8C090004, 1'b1);
        repeat (2) @(negedge clk);
        if (wr_count - base !== 2 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h20080005 ||
            wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h8C090004) begin
            errors++;
            $display("[TB] FAIL gaps_log n=%0d w0=%h@%h w1=%h@%h required=2 20080005@0 8c090004@4",
                     wr_count - base, wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]);
        end
        checks++;
        if (done !== 1'b1 || words_loaded !== 16'd2) begin
            errors++;
            $display("[TB] FAIL gaps_done done=%b words=%0d required=1/2", done, words_loaded);
        end
        checks++;
    endtask

    // A reset in the middle of word 0 drops the partial word. A fresh image
    // sent afterwards loads cleanly.
    task automatic test_midload_reset();
        do_reset();
        base = wr_count;
        send_hdr(16'd1, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        do_reset();
        send_hdr(16'd1, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        repeat (2) @(negedge clk);
        if (wr_count - base !== 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL midreset_log n=%0d w0=%h@%h required=1 deadbeef@0",
                     wr_count - base, wr_data[base], wr_addr[base]);
        end
        checks++;
        if (done !== 1'b1 || words_loaded !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midreset_done done=%b words=%0d required=1/1", done, words_loaded);
        end
        checks++;
    endtask

    // Starts from DONE, which the previous test left behind. A start pulse
    // coincides with a valid byte, and that byte must not be taken. During
    // the reload, a start pulse in DATA must be ignored.
    task automatic test_restart();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        if (cpu_resetN !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || words_loaded !== 16'd0) begin
            errors++;
            $display("[TB] FAIL restart_state cpu_resetN=%b done=%b ready=%b words=%0d required=0/0/1/0",
                     cpu_resetN, done, in_ready, words_loaded);
        end
        checks++;
        base = wr_count;
        send_hdr(16'd1, 1'b0);
        send_byte(8'h00, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (2) @(negedge clk);
        if (wr_count - base !== 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL restart_log n=%0d w0=%h@%h required=1 00000000@0",
                     wr_count - base, wr_data[base], wr_addr[base]);
        end
        checks++;
        if (done !== 1'b1 || words_loaded !== 16'd1) begin
            errors++;
            $display("[TB] FAIL restart_done done=%b words=%0d required=1/1", done, words_loaded);
        end
        checks++;
    endtask

    // An image that fills memory exactly (count == 256) is legal. Its last
    // write lands at 0x3FC.
    task automatic test_full_depth();
        logic [31:0] w;
        do_reset();
        base = wr_count;
        send_hdr(16'd256, 1'b0);
        for (int i = 0; i < 256; i++) begin
            w = 32'hA5000000 | 32'(i);
            send_word(w, 1'b0);
        end
        repeat (2) @(negedge clk);
        if (wr_count - base !== 256 || wr_addr[base+255] !== 32'h3FC ||
            wr_data[base+255] !== 32'hA50000FF || wr_data[base+17] !== 32'hA5000011) begin
            errors++;
            $display("[TB] FAIL full_log n=%0d last=%h@%h w17=%h required=256 a50000ff@3fc a5000011",
                     wr_count - base, wr_data[base+255], wr_addr[base+255], wr_data[base+17]);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd256) begin
            errors++;
            $display("[TB] FAIL full_done done=%b error=%b words=%0d required=1/0/256",
                     done, error, words_loaded);
        end
        checks++;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_oversize();
        test_gaps();
        test_midload_reset();
        test_restart();
        test_full_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
